// File: rtl/mosfet_pkg.sv
// Shared types, sizes and the triode/saturation region test for the MOSFET evaluator.
package mosfet_pkg;

  localparam int unsigned N_TR  = 6;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SUM_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Widened to 4 bits so V_DS+1 cannot wrap.
  function automatic logic is_triode(input logic [2:0] vgs, input logic [2:0] vds);
    return ({1'b0, vgs} > ({1'b0, vds} + 4'd1));
  endfunction

endpackage

// File: rtl/mosfet_cell.sv
// Combinational single-transistor evaluator: drain current (sel=1) or
// transconductance (sel=0), floor-divided by 3.
module mosfet_cell
  import mosfet_pkg::*;
(
  input  logic [2:0]       w_i,
  input  logic [2:0]       v_gs_i,
  input  logic [2:0]       v_ds_i,
  input  logic             sel_i,
  output logic [VAL_W-1:0] val_o
);

  logic [4:0] vov;
  logic [5:0] tri_f;
  logic [9:0] num;

  always_comb begin
    vov   = {2'b00, v_gs_i} - 5'd1;
    tri_f = {vov, 1'b0} - {3'b000, v_ds_i};
    num   = '0;
    if (v_gs_i == 3'd0) begin
      num = '0;
    end else if (is_triode(v_gs_i, v_ds_i)) begin
      if (sel_i) num = 10'(w_i) * 10'(v_ds_i) * 10'(tri_f);
      else       num = 10'(w_i) * 10'(v_ds_i) * 10'd2;
    end else begin
      if (sel_i) num = 10'(w_i) * 10'(vov) * 10'(vov);
      else       num = 10'(w_i) * 10'(vov) * 10'd2;
    end
    val_o = VAL_W'(num / 10'd3);
  end

endmodule

// File: rtl/mosfet_seq_eval.sv
// Streaming MOSFET evaluator: 6-beat frame in, insertion-sorted ID/gm values,
// one averaged 8-bit result strobed out per complete frame.
module mosfet_seq_eval
  import mosfet_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [2:0]       W,
  input  logic [2:0]       V_GS,
  input  logic [2:0]       V_DS,
  output logic             out_valid,
  output logic [VAL_W-1:0] out_n
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [VAL_W-1:0] arr_q [N_TR];
  logic [VAL_W-1:0] arr_d [N_TR];
  logic [VAL_W-1:0] base  [N_TR];
  logic             out_valid_q;
  logic [VAL_W-1:0] out_n_q;

  logic             first_beat, load_beat, emit, last_beat;
  logic [VAL_W-1:0] cell_val, result;
  logic [SUM_W-1:0] sa, sb, sc;

  mosfet_cell u_cell (
    .w_i    (W),
    .v_gs_i (V_GS),
    .v_ds_i (V_DS),
    .sel_i  (first_beat ? mode[0] : mode_q[0]),
    .val_o  (cell_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign last_beat = (cnt_q == CNT_W'(N_TR - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    if (!in_valid) state_d = IDLE;
               else if (last_beat) state_d = OUT;
      OUT:     state_d = in_valid ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    first_beat = in_valid && (state_q != LOAD);
    load_beat  = in_valid && (state_q == LOAD);
    emit       = (state_q == OUT);
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (first_beat) begin
      cnt_d  = CNT_W'(1);
      mode_d = mode;
    end else if (load_beat) begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Descending insert; new value lands after any equal entries.
  always_comb begin
    for (int unsigned i = 0; i < N_TR; i++) begin
      base[i]  = first_beat ? '0 : arr_q[i];
      arr_d[i] = arr_q[i];
    end
    if (first_beat || load_beat) begin
      arr_d[0] = (base[0] >= cell_val) ? base[0] : cell_val;
      for (int unsigned i = 1; i < N_TR; i++) begin
        if (base[i] >= cell_val)        arr_d[i] = base[i];
        else if (base[i-1] >= cell_val) arr_d[i] = cell_val;
        else                            arr_d[i] = base[i-1];
      end
    end
  end

  always_comb begin
    sa = SUM_W'(mode_q[1] ? arr_q[0] : arr_q[3]);
    sb = SUM_W'(mode_q[1] ? arr_q[1] : arr_q[4]);
    sc = SUM_W'(mode_q[1] ? arr_q[2] : arr_q[5]);
    if (mode_q[0]) result = VAL_W'((SUM_W'(3) * sa + SUM_W'(4) * sb + SUM_W'(5) * sc) / SUM_W'(12));
    else           result = VAL_W'((sa + sb + sc) / SUM_W'(3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_q      <= '0;
      arr_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      arr_q       <= arr_d;
      out_valid_q <= emit;
      out_n_q     <= emit ? result : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_mosfet_seq_eval.sv
// Directed scoreboard bench for mosfet_seq_eval: expected results and their
// due cycle are queued when a frame completes and checked at the output strobe.
module tb_mosfet_seq_eval;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode;
  logic [2:0] W, V_GS, V_DS;
  logic       out_valid;
  logic [7:0] out_n;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [2:0] bw [6];
  logic [2:0] bg [6];
  logic [2:0] bd [6];

  mosfet_seq_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_n", 32'(out_n), 32'(e.val));
        chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_out_n", 32'(out_n), 32'd0);
      if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
        e = sb_q.pop_front();
        chk("missing_strobe", 32'(out_valid), 32'd1);
      end
    end
  end

  task automatic beat(input logic [1:0] m, input logic [2:0] w, input logic [2:0] g,
                      input logic [2:0] d);
    in_valid = 1'b1;
    mode     = m;
    W        = w;
    V_GS     = g;
    V_DS     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    mode     = 2'b00;
    W        = '0;
    V_GS     = '0;
    V_DS     = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // nb < 6 drives a truncated frame that must produce nothing.
  task automatic frame(input logic [1:0] m, input bit uniform, input int nb, input int expv);
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      if (uniform) beat(m, 3'd1, 3'd3, 3'd3);
      else         beat(m, bw[i], bg[i], bd[i]);
    end
    if (nb == 6) begin
      e.val = expv;
      e.due = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    bw = '{3'd7, 3'd7, 3'd3, 3'd1, 3'd2, 3'd5};
    bg = '{3'd7, 3'd7, 3'd4, 3'd2, 3'd5, 3'd3};
    bd = '{3'd7, 3'd1, 3'd2, 3'd5, 3'd6, 3'd4};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    W        = '0;
    V_GS     = '0;
    V_DS     = '0;
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_n", 32'(out_n), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    frame(2'b00, 1'b0, 6, 2);   idle(3);
    frame(2'b10, 1'b0, 6, 13);  idle(3);
    frame(2'b11, 1'b0, 6, 33);  idle(3);
    frame(2'b01, 1'b0, 6, 4);   idle(3);
    frame(2'b11, 1'b1, 6, 1);   idle(3);

    frame(2'b00, 1'b0, 3, 0);   idle(4);
    frame(2'b00, 1'b0, 6, 2);   idle(3);

    frame(2'b11, 1'b0, 3, 0);
    in_valid = 1'b1;
    W = bw[3]; V_GS = bg[3]; V_DS = bd[3];
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midframe_rst_out_n", 32'(out_n), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);

    frame(2'b11, 1'b0, 6, 33);
    frame(2'b00, 1'b0, 6, 2);
    idle(5);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
